// File: rtl/weight_loader_if.sv
// Weight stream channel into the weight loader: a single valid/ready word stream.
// The producer drives s_valid/s_data, the loader answers with s_ready.
interface weight_loader_if #(
   parameter int W_BITWIDTH = 8
);
   logic                  s_valid;
   logic                  s_ready;
   logic [W_BITWIDTH-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/weight_loader.sv
// Weight buffer write front end: demultiplexes one weight stream column-major into per-column FIFOs.
// Optional `WEIGHT_LOADER_CHECK_EN builds a sticky protocol-error flag on err.
module weight_loader #(
   parameter int SYS_COLS   = 4,
   parameter int W_BITWIDTH = 8,
   parameter int W_ROWS     = 16,
   parameter int TILE_W     = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [TILE_W-1:0]              num_tiles,
   weight_loader_if.slave                 strm,
   input  logic [SYS_COLS-1:0]            col_full,
   output logic [SYS_COLS-1:0]            col_wr_en,
   output logic [SYS_COLS*W_BITWIDTH-1:0] col_wr_data,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);
   localparam int ROW_W = (W_ROWS > 1) ? $clog2(W_ROWS) : 1;
   localparam int COL_W = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(W_ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(SYS_COLS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t             state_q, state_d;
   logic [ROW_W-1:0]   row_cnt;
   logic [COL_W-1:0]   col_cnt;
   logic [TILE_W-1:0]  tile_cnt;
   logic [TILE_W-1:0]  tiles_reg;
   logic               fire;
   logic               last_word;

   // Only the FIFO currently being filled can stall the stream.
   assign strm.s_ready = (state_q == LOAD) && !col_full[col_cnt];
   assign fire         = strm.s_valid && strm.s_ready;
   assign last_word    = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST)
                         && (tile_cnt == tiles_reg - TILE_W'(1));

   assign col_wr_data = {SYS_COLS{strm.s_data}};
   assign busy        = (state_q == LOAD);
   assign done        = (state_q == DONE);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      col_wr_en = '0;
      if (fire) col_wr_en[col_cnt] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    if (fire && last_word) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt   <= '0;
         col_cnt   <= '0;
         tile_cnt  <= '0;
         tiles_reg <= '0;
      end else if (state_q == IDLE && start) begin
         tiles_reg <= (num_tiles == '0) ? TILE_W'(1) : num_tiles;
         row_cnt   <= '0;
         col_cnt   <= '0;
         tile_cnt  <= '0;
      end else if (fire) begin
         if (row_cnt == ROW_LAST) begin
            row_cnt <= '0;
            if (col_cnt == COL_LAST) begin
               col_cnt  <= '0;
               tile_cnt <= tile_cnt + TILE_W'(1);
            end else begin
               col_cnt <= col_cnt + COL_W'(1);
            end
         end else begin
            row_cnt <= row_cnt + ROW_W'(1);
         end
      end
   end

`ifdef WEIGHT_LOADER_CHECK_EN
   logic err_q;

   // Stray words outside LOAD and restarts during LOAD both latch until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if ((state_q != LOAD && strm.s_valid) || (state_q == LOAD && start)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader (SYS_COLS=4, W_ROWS=16, 8-bit words).
// A negedge monitor logs every FIFO write per column; directed steps compare against hand-derived values.
module tb_weight_loader;
   localparam int COLS = 4;
   localparam int ROWS = 16;
   localparam int TILE_WORDS = COLS * ROWS;
`ifdef WEIGHT_LOADER_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [7:0]      num_tiles;
   logic [COLS-1:0] col_full;
   logic [COLS-1:0] col_wr_en;
   logic [COLS*8-1:0] col_wr_data;
   logic            busy;
   logic            done;
   logic            err;

   weight_loader_if #(.W_BITWIDTH(8)) strm ();

   weight_loader #(
      .SYS_COLS(COLS), .W_BITWIDTH(8), .W_ROWS(ROWS), .TILE_W(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .strm(strm),
      .col_full(col_full), .col_wr_en(col_wr_en), .col_wr_data(col_wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] col_q [COLS][$];
   int onehot_bad = 0;
   int done_seen  = 0;

   always @(negedge clk) begin
      if ($countones(col_wr_en) > 1) onehot_bad++;
      for (int k = 0; k < COLS; k++)
         if (col_wr_en[k]) col_q[k].push_back(col_wr_data[k*8 +: 8]);
      if (done) done_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] nt);
      start     = 1'b1;
      num_tiles = nt;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Streams n words (data = word index); optional gaps, one 5-cycle col_full[1] burst, two stray starts.
   task automatic stream(input int n, input bit gaps, input int bp_word, input int sa, input int sb,
                         output int busy_cycles);
      int  i = 0;
      int  cyc = 0;
      int  bp_left = 0;
      bit  bp_done = 1'b0;
      bit  fire;
      busy_cycles = 0;
      strm.s_valid = 1'b0;
      while (i < n && cyc < 2000) begin
         if (!strm.s_valid) strm.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         strm.s_data = 8'(i);
         col_full = '0;
         if (i < ROWS) col_full[2] = 1'b1;
         if (i == bp_word && !bp_done) begin
            bp_left = 5;
            bp_done = 1'b1;
         end
         if (bp_left > 0) col_full[1] = 1'b1;
         start = (i == sa || i == sb);
         @(negedge clk);
         fire = strm.s_valid && strm.s_ready;
         if (bus_on(busy)) busy_cycles++;
         if (bp_left > 0) begin
            check("bp_s_ready", 32'(strm.s_ready), 32'd0);
            check("bp_wr_en", 32'(col_wr_en), 32'd0);
            bp_left--;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         if (fire) begin
            i++;
            strm.s_valid = 1'b0;
         end
      end
      strm.s_valid = 1'b0;
      col_full = '0;
      check("stream_words", 32'(i), 32'(n));
   endtask

   function automatic bit bus_on(input logic b);
      return b === 1'b1;
   endfunction

   // Runs one job and checks the done pulse plus every column's written sequence.
   task automatic run_job(input string name, input logic [7:0] nt, input int tiles, input bit gaps,
                          input int bp_word, input int sa, input int sb, output int busy_cycles);
      int base [COLS];
      int done_base;
      int got, bad, exp_len;
      logic [7:0] exp_d;
      for (int k = 0; k < COLS; k++) base[k] = col_q[k].size();
      done_base = done_seen;
      do_start(nt);
      stream(tiles * TILE_WORDS, gaps, bp_word, sa, sb, busy_cycles);
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd1);
      check({name, "_busy_in_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({name, "_done_low"}, 32'(done), 32'd0);
      @(posedge clk); #1;
      check({name, "_done_count"}, 32'(done_seen - done_base), 32'd1);
      exp_len = tiles * ROWS;
      for (int k = 0; k < COLS; k++) begin
         got = col_q[k].size() - base[k];
         check($sformatf("%s_col%0d_len", name, k), 32'(got), 32'(exp_len));
         bad = 0;
         for (int j = 0; j < got && j < exp_len; j++) begin
            exp_d = 8'((j / ROWS) * TILE_WORDS + k * ROWS + (j % ROWS));
            if (col_q[k][base[k] + j] !== exp_d) bad++;
         end
         check($sformatf("%s_col%0d_data_bad", name, k), 32'(bad), 32'd0);
      end
   endtask

   initial begin
      int bc;
      rst = 1'b1;
      start = 1'b0;
      num_tiles = '0;
      col_full = '0;
      strm.s_valid = 1'b0;
      strm.s_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_s_ready", 32'(strm.s_ready), 32'd0);
      check("rst_wr_en", 32'(col_wr_en), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;

      run_job("basic", 8'd1, 1, 1'b0, -1, -1, -1, bc);
      check("basic_busy_cycles", 32'(bc), 32'd64);
      check("basic_err", 32'(err), 32'd0);

      run_job("bp", 8'd1, 1, 1'b0, 20, -1, -1, bc);
      check("bp_busy_cycles", 32'(bc), 32'd69);

      run_job("multi3", 8'd3, 3, 1'b0, -1, -1, -1, bc);
      check("multi3_busy_cycles", 32'(bc), 32'd192);

      run_job("zero", 8'd0, 1, 1'b0, -1, -1, -1, bc);
      check("zero_busy_cycles", 32'(bc), 32'd64);

      run_job("gaps", 8'd1, 1, 1'b1, -1, 10, 40, bc);
      check("gaps_err", 32'(err), 32'(CHK));

      // Abort a job partway through column 2 with a synchronous reset.
      do_start(8'd1);
      stream(37, 1'b0, -1, -1, -1, bc);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_s_ready", 32'(strm.s_ready), 32'd0);
      check("midrst_wr_en", 32'(col_wr_en), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      run_job("after_rst", 8'd1, 1, 1'b0, -1, -1, -1, bc);

      // Stray words while idle are never accepted.
      for (int c = 0; c < 3; c++) begin
         strm.s_valid = 1'b1;
         strm.s_data = 8'hA5;
         @(negedge clk);
         check("stray_s_ready", 32'(strm.s_ready), 32'd0);
         check("stray_wr_en", 32'(col_wr_en), 32'd0);
         @(posedge clk); #1;
      end
      strm.s_valid = 1'b0;
      @(negedge clk);
      check("stray_err", 32'(err), 32'(CHK));
      check("onehot_violations", 32'(onehot_bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side front end of the weight buffer bank.
- Accepts a single valid/ready stream of weight words and demultiplexes it, column-major, into the SYS_COLS per-column weight FIFOs (their wr_en/din ports) that later feed the systolic array.
- Tracks row/column/tile position, applies per-column backpressure from FIFO full flags, and signals completion of a programmed number of tiles.

Parameters:
- SYS_COLS, 4, number of systolic columns / weight FIFOs
- W_BITWIDTH, 8, weight word width in bits
- W_ROWS, 16, words written to each column FIFO per tile
- TILE_W, 8, width of tile count input

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a load job; sampled only in IDLE
- num_tiles  input  TILE_W  tiles in this job; sampled on accepted start; 0 treated as 1
- s_valid  input  1  stream word valid
- s_ready  output  1  stream word accepted when s_valid & s_ready
- s_data  input  W_BITWIDTH  stream weight word
- col_full  input  SYS_COLS  full flag of each column FIFO
- col_wr_en  output  SYS_COLS  one-hot write enable to column FIFOs
- col_wr_data  output  SYS_COLS*W_BITWIDTH  per-column write data
- busy  output  1  high in LOAD state
- done  output  1  one-cycle pulse when job finishes
- err  output  1  sticky protocol error (only with optional feature)

Behaviour:
- Reset: state IDLE; row_cnt, col_cnt, tile_cnt, tiles_reg = 0; busy = 0, done = 0, err = 0. s_ready and col_wr_en are 0 in IDLE, so both are 0 out of reset.
- Reset mid-job aborts immediately and returns to the reset state the next cycle. Partially written FIFO contents are not rolled back.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on start=1. Latch tiles_reg = (num_tiles==0 ? 1 : num_tiles) and clear counters.
  - LOAD -> DONE on the handshake of the last word (row_cnt==W_ROWS-1, col_cnt==SYS_COLS-1, tile_cnt==tiles_reg-1).
  - DONE -> IDLE unconditionally after one cycle. done=1 only in the DONE cycle.
- start outside IDLE is ignored (includes DONE).
- s_ready = (state==LOAD) & ~col_full[col_cnt]. Combinational; s_ready does not depend on s_valid.
- Write path, zero latency:
  - col_wr_en[k] = s_valid & s_ready & (k==col_cnt).
  - col_wr_data[k] = s_data for all k; only the enabled lane is meaningful.
- Counters advance only on handshake:
  - row_cnt increments; at W_ROWS-1 it wraps to 0 and col_cnt increments.
  - col_cnt wraps at SYS_COLS-1 to 0 and tile_cnt increments.
  - Counter widths: $clog2 of their limits, minimum 1 bit.
- Stream ordering per tile: W_ROWS words for column 0, then W_ROWS for column 1, ..., then column SYS_COLS-1.
- Boundary cases:
  - col_full of a column other than col_cnt has no effect.
  - col_full rising while s_valid is held stalls with no write. No word is dropped or duplicated; s_data must be held by the source until accepted.
  - s_valid low mid-job stalls; counters hold.
  - busy = (state==LOAD).

Optional Feature:
- Macro: WEIGHT_LOADER_CHECK_EN.
- When defined, err is set and held until rst by either of:
  - s_valid=1 while state is IDLE or DONE (stray word, not accepted);
  - start=1 while state is LOAD.
- When undefined, err is tied 0 and no check logic is built.

Test Plan (SYS_COLS=4, W_ROWS=16):
- Basic load: rst, then start with num_tiles=1, stream words 0..63 with s_valid always 1 -> col_wr_en=0001 for words 0-15, 0010 for 16-31, 0100 for 32-47, 1000 for 48-63. done pulses exactly 1 cycle after word 63 is accepted; busy high for 64 cycles.
- Backpressure: col_full[1]=1 for 5 cycles starting at word 20 -> s_ready=0, no writes for those cycles. Column 1 still receives exactly words 16-31 in order; col_full[2]=1 during column 0 has no effect.
- Multi-tile and zero case:
  - num_tiles=3 -> 192 accepted words, column pattern repeats 3 times, a single done pulse.
  - num_tiles=0 -> 64 words, then done.
- Gaps and stray start: random s_valid gaps (50% duty) plus start pulses mid-job -> identical written sequence to the gap-free case; start has no effect. With WEIGHT_LOADER_CHECK_EN, err=1 after the first mid-job start.
- Reset mid-operation: rst at word 37 -> next cycle state IDLE, s_ready=0, col_wr_en=0, done=0, err=0. A new start then begins writing at column 0, row 0.
- Stray valid: s_valid=1 in IDLE for 3 cycles -> no col_wr_en, s_ready=0. err=1 only if WEIGHT_LOADER_CHECK_EN is defined, otherwise err=0.
